// File: rtl/spi_target_port.sv
// SPI mode-0 target: serves queued {addr,data} words on MISO and captures MOSI bytes.
// All SPI inputs are resynchronised into clk; frames are decoded from synchronised edges.
module spi_target_port #(
    parameter int TX_W   = 12,
    parameter int RX_W   = 8,
    parameter int FIFO_D = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sclk_in,
    input  logic                        cs_n_in,
    input  logic                        mosi_in,
    output logic                        miso_out,
    output logic                        miso_oe_out,
    input  logic [TX_W-1:0]             tx_data_in,
    input  logic                        tx_valid_in,
    output logic                        tx_ready_out,
    output logic [RX_W-1:0]             rx_data_out,
    output logic                        rx_valid_out,
    input  logic                        rx_ready_in,
    output logic [$clog2(FIFO_D):0]     tx_level_out,
    output logic [$clog2(FIFO_D):0]     rx_level_out,
    output logic                        busy_out,
    output logic                        underrun_out,
    output logic                        overflow_out,
    output logic                        frame_err_out,
    input  logic                        clr_err_in
);
    localparam int AW = $clog2(FIFO_D);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        IDLE    = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [2:0]        sclk_sync_r, cs_sync_r;
    logic [1:0]        mosi_sync_r;
    logic              sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
    logic              start_s, end_s, active_s;
    logic [TX_W-1:0]   tx_shift_r, tx_start_word_s;
    logic [RX_W-1:0]   rx_shift_r;
    logic [4:0]        bit_cnt_r;
    logic              miso_r, act_r;
    logic [TX_W-1:0]   tx_mem_r [FIFO_D];
    logic [RX_W-1:0]   rx_mem_r [FIFO_D];
    logic [AW-1:0]     tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
    logic [LW-1:0]     tx_level_r, rx_level_r;
    logic              tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, rx_full_s;
    logic              rx_frame_s, tx_frame_s;
    logic              underrun_r, overflow_r, frame_err_r;

    // Index 1 is the synchronised level, index 2 the previous value for edge detect.
    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign cs_fall_s   = ~cs_sync_r[1] & cs_sync_r[2];
    assign cs_rise_s   = cs_sync_r[1] & ~cs_sync_r[2];
    assign active_s    = (state_r == ACTIVE);

    assign rx_full_s   = (rx_level_r == LW'(FIFO_D));
    assign rx_frame_s  = (bit_cnt_r == 5'(RX_W));
    assign tx_frame_s  = (bit_cnt_r == 5'(TX_W));
    assign tx_push_s   = tx_valid_in & tx_ready_out;
    assign tx_pop_s    = start_s & (tx_level_r != {LW{1'b0}});
    assign rx_push_s   = end_s & rx_frame_s & ~rx_full_s;
    assign rx_pop_s    = rx_ready_in & (rx_level_r != {LW{1'b0}});
    assign tx_start_word_s = tx_pop_s ? tx_mem_r[tx_rd_ptr_r] : {TX_W{1'b0}};

    assign tx_ready_out  = (tx_level_r != LW'(FIFO_D));
    assign rx_valid_out  = (rx_level_r != {LW{1'b0}});
    assign rx_data_out   = rx_mem_r[rx_rd_ptr_r];
    assign tx_level_out  = tx_level_r;
    assign rx_level_out  = rx_level_r;
    assign miso_out      = miso_r;
    assign miso_oe_out   = act_r;
    assign busy_out      = act_r;
    assign underrun_out  = underrun_r;
    assign overflow_out  = overflow_r;
    assign frame_err_out = frame_err_r;

    // Input synchronisers; cs resets low so a frame already running at reset is not mistaken for idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b000;
            mosi_sync_r <= 2'b00;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], sclk_in};
            cs_sync_r   <= {cs_sync_r[1:0], cs_n_in};
            mosi_sync_r <= {mosi_sync_r[0], mosi_in};
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_HI;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame FSM next state and frame start/end strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        end_s       = 1'b0;
        case (state_r)
            WAIT_HI: begin
                if (cs_sync_r[1]) state_nxt_s = IDLE;
                else              state_nxt_s = WAIT_HI;
            end
            IDLE: begin
                if (cs_fall_s) begin
                    state_nxt_s = ACTIVE;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    state_nxt_s = IDLE;
                    end_s       = 1'b1;
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            default: state_nxt_s = WAIT_HI;
        endcase
    end

    // Shift registers, bit counter and MISO/output-enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_r <= {TX_W{1'b0}};
            rx_shift_r <= {RX_W{1'b0}};
            bit_cnt_r  <= 5'd0;
            miso_r     <= 1'b0;
            act_r      <= 1'b0;
        end else begin
            act_r <= (state_nxt_s == ACTIVE);
            if (start_s) begin
                tx_shift_r <= tx_start_word_s;
                miso_r     <= tx_start_word_s[TX_W-1];
                bit_cnt_r  <= 5'd0;
            end else if (active_s && !end_s) begin
                if (sclk_rise_s) begin
                    rx_shift_r <= {rx_shift_r[RX_W-2:0], mosi_sync_r[1]};
                    if (bit_cnt_r != 5'd31) bit_cnt_r <= bit_cnt_r + 5'd1;
                end
                if (sclk_fall_s) begin
                    tx_shift_r <= {tx_shift_r[TX_W-2:0], 1'b0};
                    miso_r     <= tx_shift_r[TX_W-2];
                end
            end else begin
                miso_r <= 1'b0;
            end
        end
    end

    // TX queue: host pushes words, frame start pops the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_r <= {AW{1'b0}};
            tx_rd_ptr_r <= {AW{1'b0}};
            tx_level_r  <= {LW{1'b0}};
            for (int i = 0; i < FIFO_D; i++) tx_mem_r[i] <= {TX_W{1'b0}};
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_ptr_r] <= tx_data_in;
                tx_wr_ptr_r           <= tx_wr_ptr_r + AW'(1);
            end
            if (tx_pop_s) tx_rd_ptr_r <= tx_rd_ptr_r + AW'(1);
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_level_r <= tx_level_r + LW'(1);
                2'b01:   tx_level_r <= tx_level_r - LW'(1);
                default: tx_level_r <= tx_level_r;
            endcase
        end
    end

    // RX queue: complete 8-bit frames push, host dequeues the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr_r <= {AW{1'b0}};
            rx_rd_ptr_r <= {AW{1'b0}};
            rx_level_r  <= {LW{1'b0}};
            for (int i = 0; i < FIFO_D; i++) rx_mem_r[i] <= {RX_W{1'b0}};
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wr_ptr_r] <= rx_shift_r;
                rx_wr_ptr_r           <= rx_wr_ptr_r + AW'(1);
            end
            if (rx_pop_s) rx_rd_ptr_r <= rx_rd_ptr_r + AW'(1);
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_level_r <= rx_level_r + LW'(1);
                2'b01:   rx_level_r <= rx_level_r - LW'(1);
                default: rx_level_r <= rx_level_r;
            endcase
        end
    end

    // Sticky error flags; clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst || clr_err_in) begin
            underrun_r  <= 1'b0;
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (start_s && tx_level_r == {LW{1'b0}}) underrun_r <= 1'b1;
            if (end_s && rx_frame_s && rx_full_s)    overflow_r <= 1'b1;
            if (end_s && !rx_frame_s && !tx_frame_s) frame_err_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_target_port.sv
// Self-checking bench for spi_target_port: an SPI master model drives frames,
// scoreboard queues hold the expected MISO words and received bytes.
module tb_spi_target_port;
    localparam int TX_W   = 12;
    localparam int RX_W   = 8;
    localparam int FIFO_D = 4;
    localparam int LW     = 3;

    logic            clk = 1'b0;
    logic            rst, sclk, cs_n, mosi, miso, miso_oe;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid, tx_ready;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid, rx_ready;
    logic [LW-1:0]   tx_level, rx_level;
    logic            busy, underrun, overflow, frame_err, clr_err;

    int total = 0;
    int bad   = 0;
    logic [TX_W-1:0] exp_tx_q [$];
    logic [RX_W-1:0] exp_rx_q [$];

    spi_target_port #(.TX_W(TX_W), .RX_W(RX_W), .FIFO_D(FIFO_D)) dut (
        .clk(clk), .rst(rst), .sclk_in(sclk), .cs_n_in(cs_n), .mosi_in(mosi),
        .miso_out(miso), .miso_oe_out(miso_oe),
        .tx_data_in(tx_data), .tx_valid_in(tx_valid), .tx_ready_out(tx_ready),
        .rx_data_out(rx_data), .rx_valid_out(rx_valid), .rx_ready_in(rx_ready),
        .tx_level_out(tx_level), .rx_level_out(rx_level), .busy_out(busy),
        .underrun_out(underrun), .overflow_out(overflow), .frame_err_out(frame_err),
        .clr_err_in(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic clk_bit(input logic b, output logic m);
        mosi = b;
        wait_clk(6);
        m = miso;
        sclk = 1'b1;
        wait_clk(6);
        sclk = 1'b0;
    endtask

    task automatic cs_high();
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic spi_frame(input int n, input logic [31:0] w, output logic [31:0] m);
        logic b;
        m = 32'd0;
        cs_low();
        for (int i = n - 1; i >= 0; i--) begin
            clk_bit(w[i], b);
            m = {m[30:0], b};
        end
        cs_high();
    endtask

    task automatic enqueue(input logic [TX_W-1:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        exp_tx_q.push_back(w);
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = 12'h000; tx_valid = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
        wait_clk(4);
        total++;
        if ({miso, miso_oe, busy, tx_ready, rx_valid} !== 5'b00010) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b", {miso, miso_oe, busy, tx_ready, rx_valid}, 5'b00010);
        end
        total++;
        if ({rx_data, tx_level, rx_level, underrun, overflow, frame_err} !== 17'd0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=%h",
                     {rx_data, tx_level, rx_level, underrun, overflow, frame_err}, 17'd0);
        end
        rst = 1'b0;
        wait_clk(10);
    endtask

    task automatic test_read();
        logic [31:0] m;
        logic        b;
        enqueue(12'hA5C);
        total++;
        if (tx_level !== 3'd1) begin bad++; $display("FAIL read_lvl1 got=%0d exp=1", tx_level); end
        m = 32'd0;
        cs_low();
        total++;
        if ({busy, miso_oe} !== 2'b11) begin bad++; $display("FAIL read_busy got=%b exp=11", {busy, miso_oe}); end
        for (int i = 0; i < TX_W; i++) begin
            clk_bit(1'b0, b);
            m = {m[30:0], b};
        end
        cs_high();
        total++;
        if (m[TX_W-1:0] !== exp_tx_q[0]) begin
            bad++; $display("FAIL read_miso got=%h exp=%h", m[TX_W-1:0], exp_tx_q[0]);
        end
        void'(exp_tx_q.pop_front());
        total++;
        if ({tx_level, underrun, overflow, frame_err, busy} !== 7'd0) begin
            bad++; $display("FAIL read_after got=%b exp=0", {tx_level, underrun, overflow, frame_err, busy});
        end
    endtask

    task automatic test_write();
        logic [31:0] m;
        spi_frame(RX_W, 32'h3E, m);
        exp_rx_q.push_back(8'h3E);
        total++;
        if ({rx_valid, rx_level} !== {1'b1, 3'd1}) begin
            bad++; $display("FAIL write_lvl got=%b exp=1001", {rx_valid, rx_level});
        end
        total++;
        if (rx_data !== exp_rx_q[0]) begin bad++; $display("FAIL write_data got=%h exp=%h", rx_data, exp_rx_q[0]); end
        void'(exp_rx_q.pop_front());
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        total++;
        if (rx_valid !== 1'b0) begin bad++; $display("FAIL write_deq got=%b exp=0", rx_valid); end
        clear_flags();
    endtask

    task automatic test_underrun();
        logic [31:0] m;
        spi_frame(TX_W, 32'h0, m);
        total++;
        if (m[TX_W-1:0] !== 12'h000) begin bad++; $display("FAIL underrun_miso got=%h exp=000", m[TX_W-1:0]); end
        total++;
        if ({underrun, overflow, frame_err} !== 3'b100) begin
            bad++; $display("FAIL underrun_flag got=%b exp=100", {underrun, overflow, frame_err});
        end
        clear_flags();
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clr got=%b exp=0", underrun); end
    endtask

    task automatic test_overflow();
        logic [31:0] m;
        logic [7:0]  v;
        for (int k = 1; k <= 5; k++) begin
            v = 8'h11 * 8'(k);
            spi_frame(RX_W, {24'd0, v}, m);
            if (k <= FIFO_D) exp_rx_q.push_back(v);
        end
        total++;
        if ({overflow, rx_level} !== {1'b1, 3'd4}) begin
            bad++; $display("FAIL ovf_flag got=%b exp=1100", {overflow, rx_level});
        end
        for (int g = 0; g < 8 && rx_valid; g++) begin
            total++;
            if (exp_rx_q.size() == 0) begin
                bad++; $display("FAIL ovf_extra got=%h exp=none", rx_data);
            end else begin
                if (rx_data !== exp_rx_q[0]) begin
                    bad++; $display("FAIL ovf_drain got=%h exp=%h", rx_data, exp_rx_q[0]);
                end
                void'(exp_rx_q.pop_front());
            end
            rx_ready = 1'b1;
            wait_clk(1);
            rx_ready = 1'b0;
        end
        total++;
        if (exp_rx_q.size() != 0) begin bad++; $display("FAIL ovf_missing got=%0d exp=0", exp_rx_q.size()); end
        clear_flags();
    endtask

    task automatic test_frame_err();
        logic [31:0] m;
        spi_frame(5, 32'h15, m);
        total++;
        if ({frame_err, rx_level} !== {1'b1, 3'd0}) begin
            bad++; $display("FAIL ferr_flag got=%b exp=1000", {frame_err, rx_level});
        end
        spi_frame(RX_W, 32'hA7, m);
        exp_rx_q.push_back(8'hA7);
        total++;
        if ({rx_level, rx_data} !== {3'd1, exp_rx_q[0]}) begin
            bad++; $display("FAIL ferr_next got=%h exp=%h", {rx_level, rx_data}, {3'd1, exp_rx_q[0]});
        end
        void'(exp_rx_q.pop_front());
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        clear_flags();
    endtask

    task automatic test_back_to_back();
        logic [31:0] m;
        logic [TX_W-1:0] w;
        tx_valid = 1'b1;
        for (int k = 0; k < FIFO_D; k++) begin
            w = 12'h3C1 + 12'(k * 12'h111);
            tx_data = w;
            exp_tx_q.push_back(w);
            wait_clk(1);
        end
        tx_data = 12'hFFF;
        wait_clk(1);
        tx_valid = 1'b0;
        total++;
        if ({tx_ready, tx_level} !== {1'b0, 3'd4}) begin
            bad++; $display("FAIL b2b_full got=%b exp=0100", {tx_ready, tx_level});
        end
        for (int k = 0; k < FIFO_D; k++) begin
            spi_frame(TX_W, 32'h0, m);
            total++;
            if (m[TX_W-1:0] !== exp_tx_q[0]) begin
                bad++; $display("FAIL b2b_miso got=%h exp=%h", m[TX_W-1:0], exp_tx_q[0]);
            end
            void'(exp_tx_q.pop_front());
        end
        total++;
        if ({tx_level, underrun} !== 4'd0) begin
            bad++; $display("FAIL b2b_end got=%b exp=0000", {tx_level, underrun});
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] m;
        logic        b;
        enqueue(12'h7E1);
        cs_low();
        for (int i = 0; i < 3; i++) clk_bit(1'b1, b);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        exp_tx_q.delete();
        wait_clk(1);
        total++;
        if ({miso, miso_oe, busy, tx_ready, tx_level, rx_level} !== {4'b0001, 6'd0}) begin
            bad++; $display("FAIL mrst_state got=%b exp=0001000000", {miso, miso_oe, busy, tx_ready, tx_level, rx_level});
        end
        for (int i = 0; i < 5; i++) clk_bit(1'b1, b);
        total++;
        if ({busy, rx_level, frame_err, underrun} !== 6'd0) begin
            bad++; $display("FAIL mrst_ignore got=%b exp=000000", {busy, rx_level, frame_err, underrun});
        end
        cs_high();
        spi_frame(RX_W, 32'h5A, m);
        exp_rx_q.push_back(8'h5A);
        total++;
        if ({rx_level, rx_data, frame_err} !== {3'd1, exp_rx_q[0], 1'b0}) begin
            bad++; $display("FAIL mrst_next got=%h exp=%h", {rx_level, rx_data, frame_err}, {3'd1, exp_rx_q[0], 1'b0});
        end
        void'(exp_rx_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_underrun();
        test_overflow();
        test_frame_err();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_target_port.md
Name: spi_target_port

Overview:
- SPI responder (target) that sits at the far end of the processor's SPI master port. It models or implements the peripheral the core talks to.
- It serves processor reads by shifting queued 12-bit words ({addr[3:0], data[7:0]}) out on MISO.
- It captures processor sends: 8-bit MOSI frames go into an RX queue.
- Used as the host-side loader and output sink in the FPGA demo and in the chip-level bench.

Parameters:
- TX_W, 12, bits per outgoing frame (addr nibble + data byte), MSB first.
- RX_W, 8, bits per incoming frame, MSB first.
- FIFO_D, 4, depth of each of the TX and RX queues (power of 2, ≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- sclk_in  in  1  SPI clock from the processor; asynchronous to clk.
- cs_n_in  in  1  chip select from the processor, active-low; asynchronous.
- mosi_in  in  1  serial data from the processor.
- miso_out  out  1  serial data to the processor.
- miso_oe_out  out  1  high while a frame is active (drives the shared bidirectional pin).
- tx_data_in  in  TX_W  word to enqueue for the next read frame.
- tx_valid_in  in  1  enqueue request.
- tx_ready_out  out  1  TX queue not full.
- rx_data_out  out  RX_W  head of the RX queue.
- rx_valid_out  out  1  RX queue not empty.
- rx_ready_in  in  1  dequeue the RX head.
- tx_level_out  out  clog2(FIFO_D)+1  TX occupancy.
- rx_level_out  out  clog2(FIFO_D)+1  RX occupancy.
- busy_out  out  1  frame in progress.
- underrun_out  out  1  sticky: a frame started with the TX queue empty.
- overflow_out  out  1  sticky: a complete RX frame arrived with the RX queue full.
- frame_err_out  out  1  sticky: a frame ended with a bit count other than RX_W or TX_W.
- clr_err_in  in  1  clears all sticky flags.

Behaviour:
- Input sync: sclk_in, cs_n_in and mosi_in each pass through 2-flop synchronizers, plus a third flop for edge detect.
- Timing requirement: each SCLK half-period and the CS setup time are ≥4 clk cycles. Behaviour below is relative to the synchronized edges.
- SPI mode 0: sample MOSI on SCLK rising; update MISO on SCLK falling.
- FSM states:
  - WAIT_HI: entered after reset. Leave for IDLE on the first synchronized cs_n=1. A frame already in progress at reset is therefore ignored.
  - IDLE → ACTIVE on cs_n falling.
    - Pop the TX head into tx_shift and drive MISO = tx_shift[TX_W-1] on the same cycle.
    - If the TX queue is empty: tx_shift=0 and set underrun.
    - Clear bit_cnt.
  - ACTIVE, SCLK rising: rx_shift <= {rx_shift[RX_W-2:0], mosi}; bit_cnt++ (saturating at 2^5-1).
  - ACTIVE, SCLK falling: tx_shift <<= 1, filling with 0. After TX_W bits MISO stays 0.
  - ACTIVE → IDLE on cs_n rising:
    - bit_cnt == RX_W: push rx_shift to the RX queue. If the queue is full, drop the word and set overflow.
    - bit_cnt == TX_W: read frame complete; nothing pushed.
    - Any other bit_cnt: set frame_err; nothing pushed.
- Frame length rule: when RX_W == TX_W, every frame is both a read and a write.
- miso_oe_out = (state == ACTIVE). miso_out = 0 whenever not ACTIVE.
- busy_out = (state == ACTIVE).
- Queues: synchronous FIFOs with wrap-around pointers and a level counter.
  - Enqueue when valid & ready. At full, tx_ready_out = 0 even if a pop occurs in the same cycle.
  - RX: a push and a dequeue in the same cycle at non-empty keep the level unchanged. At empty, a dequeue is ignored.
  - TX: a push and a frame-start pop in the same cycle are both honoured. At empty, the pop sees the empty queue (underrun); the pushed word remains queued.
- Sticky flags: clr_err_in has priority over a same-cycle set.
- Reset values: miso_out=0, miso_oe_out=0, busy_out=0, tx_ready_out=1, rx_valid_out=0, rx_data_out=0, levels=0, all flags=0, state=WAIT_HI.

Test Plan:
- Enqueue 12'hA5C, then a 12-SCLK read frame → MISO bits 1010_0101_1100, tx_level 1→0, no flags set.
- MOSI 8-bit frame 0x3E → rx_valid=1, rx_data=0x3E, rx_level=1; rx_ready for 1 cycle → rx_valid=0.
- Read frame with an empty TX queue → MISO all 0, underrun=1; then clr_err_in → underrun=0.
- Four 0x11..0x44 RX frames with no dequeue, then a fifth 0x55 → overflow=1, rx_level=4, queue drains 0x11,0x22,0x33,0x44.
- Frame with 5 SCLKs → frame_err=1, rx_level unchanged; the next valid 8-bit frame is received correctly.
- rst asserted mid-frame (cs_n low) → outputs at reset values, remaining SCLKs ignored until cs_n high; the following frame works normally.
